// File: rtl/bn_pkg.sv
// Shared types and helpers for the batch-norm sequencing controller.
package bn_pkg;

   typedef enum logic [1:0] {
      eEMPTY,
      eHALF,
      eFULL
   } pipe_e;

   // A one-channel frame still needs a 1-bit counter/address.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bn_chan_counter.sv
// Channel counter that wraps at SIZE, with enable and synchronous clear.
module bn_chan_counter #(
   parameter int SIZE = 1,
   parameter int W    = 1
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] count_o,
   output logic         last_o
);

   localparam logic [W-1:0] MAX = W'(SIZE - 1);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   assign count_o = count_q;
   assign last_o  = (count_q == MAX);

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = last_o ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/bn_ctrl.sv
// Two-stage enable sequencer for the BN datapath (ROM latency absorbed in stage 1).
// Optional frame counter output enabled by BN_CTRL_STATS_EN.
module bn_ctrl
   import bn_pkg::*;
#(
   parameter int INPUT_SIZE = 1,
   parameter int CNT_W      = cnt_w(INPUT_SIZE)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             flush_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic             load_o,
   output logic [CNT_W-1:0] addr_o,
   output logic             compute_en_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic             last_o,
   output logic             frame_done_o
`ifdef BN_CTRL_STATS_EN
   ,
   output logic [15:0]      frame_count_o
`endif
);

   logic  v1_q, v1_d;
   logic  v2_q, v2_d;
   logic  last1_q, last1_d;
   logic  last2_q, last2_d;
   logic  accept;
   logic  advance2;
   logic  cnt_last;
   pipe_e pipe_s;

   assign advance2     = v2_q && ready_i;
   assign compute_en_o = v1_q && (!v2_q || ready_i);
   assign ready_o      = !flush_i && (!v1_q || compute_en_o);
   assign accept       = valid_i && ready_o;
   assign load_o       = accept;

   assign valid_o      = v2_q;
   assign last_o       = last2_q && v2_q;
   assign frame_done_o = advance2 && last2_q;

   bn_chan_counter #(
      .SIZE (INPUT_SIZE),
      .W    (CNT_W)
   ) u_cnt (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clr_i   (flush_i),
      .en_i    (accept),
      .count_o (addr_o),
      .last_o  (cnt_last)
   );

   always_comb begin
      v1_d    = accept || (v1_q && !compute_en_o);
      v2_d    = compute_en_o || (v2_q && !ready_i);
      last1_d = accept ? cnt_last : last1_q;
      last2_d = compute_en_o ? last1_q : last2_q;
      if (flush_i) begin
         v1_d    = 1'b0;
         v2_d    = 1'b0;
         last1_d = 1'b0;
         last2_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         last1_q <= 1'b0;
         last2_q <= 1'b0;
      end else begin
         v1_q    <= v1_d;
         v2_q    <= v2_d;
         last1_q <= last1_d;
         last2_q <= last2_d;
      end
   end

`ifdef BN_CTRL_STATS_EN
   logic [15:0] frame_cnt_q;
   logic [15:0] frame_cnt_d;

   assign frame_count_o = frame_cnt_q;

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (flush_i) begin
         frame_cnt_d = '0;
      end else if (frame_done_o) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         frame_cnt_q <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
      end
   end
`endif

   always_comb begin
      unique case ({v1_q, v2_q})
         2'b00:   pipe_s = eEMPTY;
         2'b11:   pipe_s = eFULL;
         default: pipe_s = eHALF;
      endcase
   end

   // A full pipe facing a stalled consumer must refuse new words.
   a_full_stall : assert property (
      @(posedge clk_i) disable iff (!reset_i)
      (pipe_s == eFULL && !ready_i) |-> !ready_o
   );

endmodule

// File: tb/tb_bn_ctrl.sv
// Bench for bn_ctrl: directed vector table on INPUT_SIZE=4, then random traffic
// on INPUT_SIZE=4 and INPUT_SIZE=1 against a queue-based occupancy model.
module tb_bn_ctrl;

   logic       clk;
   logic       rst_n;
   logic       flush;
   logic       valid;
   logic       rdy_in;

   logic       r4, ld4, ce4, vo4, l4, fd4;
   logic [1:0] a4;
   logic       r1, ld1, ce1, vo1, l1, fd1;
   logic [0:0] a1;
   logic [15:0] fc4, fc1;

   int n_chk;
   int n_pass;

   bn_ctrl #(.INPUT_SIZE(4)) u4 (
      .clk_i        (clk),
      .reset_i      (rst_n),
      .flush_i      (flush),
      .valid_i      (valid),
      .ready_o      (r4),
      .load_o       (ld4),
      .addr_o       (a4),
      .compute_en_o (ce4),
      .valid_o      (vo4),
      .ready_i      (rdy_in),
      .last_o       (l4),
      .frame_done_o (fd4)
`ifdef BN_CTRL_STATS_EN
      ,
      .frame_count_o(fc4)
`endif
   );

   bn_ctrl #(.INPUT_SIZE(1)) u1 (
      .clk_i        (clk),
      .reset_i      (rst_n),
      .flush_i      (flush),
      .valid_i      (valid),
      .ready_o      (r1),
      .load_o       (ld1),
      .addr_o       (a1),
      .compute_en_o (ce1),
      .valid_o      (vo1),
      .ready_i      (rdy_in),
      .last_o       (l1),
      .frame_done_o (fd1)
`ifdef BN_CTRL_STATS_EN
      ,
      .frame_count_o(fc1)
`endif
   );

`ifndef BN_CTRL_STATS_EN
   assign fc4 = '0;
   assign fc1 = '0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic v, r, f;
      logic er, el;
      int   ea;
      logic ece, evo, elast, efd;
   } vec_t;

   vec_t tbl[$];

   typedef struct {
      int chan;
      bit st2;
   } item_t;

   item_t q4[$];
   item_t q1[$];
   int    acc4, acc1;
   logic [15:0] fcm4, fcm1;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp)
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      else
         n_pass++;
   endtask

   task automatic add(input logic v, r, f, er, el, input int ea,
                      input logic ece, evo, elast, efd);
      vec_t x;
      x.v = v; x.r = r; x.f = f; x.er = er; x.el = el; x.ea = ea;
      x.ece = ece; x.evo = evo; x.elast = elast; x.efd = efd;
      tbl.push_back(x);
   endtask

   task automatic clr_models();
      q4.delete(); q1.delete();
      acc4 = 0; acc1 = 0;
      fcm4 = '0; fcm1 = '0;
   endtask

   // In-flight words kept oldest-first; a word is in the output stage
   // or still waiting on its ROM read. Two words means the pipe is full.
   task automatic model(input int m, input int n,
                        input int ar, al, aa, ace, avo, alast, afd, afc);
      item_t q[$];
      item_t it;
      int    acc;
      logic [15:0] fc;
      bit has2, has1, e_ce, e_rdy, e_ld, e_last, e_fd;
      string p;
      if (m == 0) begin q = q4; acc = acc4; fc = fcm4; p = "n4"; end
      else        begin q = q1; acc = acc1; fc = fcm1; p = "n1"; end
      has2   = (q.size() > 0) && q[0].st2;
      has1   = (q.size() == 2) || (q.size() == 1 && !q[0].st2);
      e_ce   = has1 && (!has2 || rdy_in);
      e_rdy  = !flush && !(q.size() == 2 && !rdy_in);
      e_ld   = valid && e_rdy;
      e_last = has2 && (q[0].chan == n - 1);
      e_fd   = e_last && rdy_in;
      chk({p, " ready_o"}, ar, int'(e_rdy));
      chk({p, " load_o"}, al, int'(e_ld));
      chk({p, " addr_o"}, aa, acc % n);
      chk({p, " compute_en_o"}, ace, int'(e_ce));
      chk({p, " valid_o"}, avo, int'(has2));
      chk({p, " last_o"}, alast, int'(e_last));
      chk({p, " frame_done_o"}, afd, int'(e_fd));
`ifdef BN_CTRL_STATS_EN
      chk({p, " frame_count_o"}, afc, int'(fc));
`else
      if (afc != 0) chk({p, " frame_count_o"}, afc, 0);
`endif
      if (flush) begin
         q.delete();
         acc = 0;
         fc  = '0;
      end else begin
         if (e_fd) fc = fc + 16'd1;
         if (has2 && rdy_in) void'(q.pop_front());
         if (e_ce) q[q.size() - 1].st2 = 1'b1;
         if (e_ld) begin
            it.chan = acc % n;
            it.st2  = 1'b0;
            q.push_back(it);
            acc++;
         end
      end
      if (m == 0) begin q4 = q; acc4 = acc; fcm4 = fc; end
      else        begin q1 = q; acc1 = acc; fcm1 = fc; end
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      valid  = 1'b0;
      rdy_in = 1'b1;
      flush  = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clr_models();
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;

      //   v r f | rdy ld addr ce vo last fd
      add(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      add(1, 1, 0, 1, 1, 0, 0, 0, 0, 0);
      add(1, 1, 0, 1, 1, 1, 1, 0, 0, 0);
      add(1, 1, 0, 1, 1, 2, 1, 1, 0, 0);
      add(1, 1, 0, 1, 1, 3, 1, 1, 0, 0);
      add(1, 1, 0, 1, 1, 0, 1, 1, 0, 0);
      add(1, 1, 0, 1, 1, 1, 1, 1, 1, 1);
      add(1, 1, 0, 1, 1, 2, 1, 1, 0, 0);
      add(1, 1, 0, 1, 1, 3, 1, 1, 0, 0);
      add(0, 1, 0, 1, 0, 0, 1, 1, 0, 0);
      add(0, 1, 0, 1, 0, 0, 0, 1, 1, 1);
      add(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      add(1, 0, 0, 1, 1, 1, 1, 0, 0, 0);
      add(1, 0, 0, 0, 0, 2, 0, 1, 0, 0);
      add(1, 0, 0, 0, 0, 2, 0, 1, 0, 0);
      add(1, 0, 0, 0, 0, 2, 0, 1, 0, 0);
      add(1, 1, 0, 1, 1, 2, 1, 1, 0, 0);
      add(0, 1, 0, 1, 0, 3, 1, 1, 0, 0);
      add(0, 1, 0, 1, 0, 3, 0, 1, 0, 0);
      add(1, 0, 0, 1, 1, 3, 0, 0, 0, 0);
      add(1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
      add(1, 0, 1, 0, 0, 1, 0, 1, 1, 0);
      add(1, 1, 0, 1, 1, 0, 0, 0, 0, 0);
      add(0, 1, 0, 1, 0, 1, 1, 0, 0, 0);
      add(0, 1, 0, 1, 0, 1, 0, 1, 0, 0);
      add(0, 1, 0, 1, 0, 1, 0, 0, 0, 0);

      do_reset();
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         valid  = tbl[i].v;
         rdy_in = tbl[i].r;
         flush  = tbl[i].f;
         #1;
         chk($sformatf("vec%0d ready_o", i), int'(r4), int'(tbl[i].er));
         chk($sformatf("vec%0d load_o", i), int'(ld4), int'(tbl[i].el));
         chk($sformatf("vec%0d addr_o", i), int'(a4), tbl[i].ea);
         chk($sformatf("vec%0d compute_en_o", i), int'(ce4), int'(tbl[i].ece));
         chk($sformatf("vec%0d valid_o", i), int'(vo4), int'(tbl[i].evo));
         chk($sformatf("vec%0d last_o", i), int'(l4), int'(tbl[i].elast));
         chk($sformatf("vec%0d frame_done_o", i), int'(fd4), int'(tbl[i].efd));
      end

      do_reset();
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         valid = ($urandom_range(0, 3) != 0);
         if ((i % 64) < 40) rdy_in = ($urandom_range(0, 3) != 0);
         else               rdy_in = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 49) == 0);
         #1;
         model(0, 4, int'(r4), int'(ld4), int'(a4), int'(ce4),
               int'(vo4), int'(l4), int'(fd4), int'(fc4));
         model(1, 1, int'(r1), int'(ld1), int'(a1), int'(ce1),
               int'(vo1), int'(l1), int'(fd1), int'(fc1));
         if (i == 300) begin
            flush = 1'b0;
            #2 rst_n = 1'b0;
            #1;
            chk("async rst ready_o", int'(r4), 1);
            chk("async rst load_o", int'(ld4), int'(valid));
            chk("async rst addr_o", int'(a4), 0);
            chk("async rst compute_en_o", int'(ce4), 0);
            chk("async rst valid_o", int'(vo4), 0);
            chk("async rst last_o", int'(l4), 0);
            chk("async rst frame_done_o", int'(fd4), 0);
            chk("async rst frame_count_o", int'(fc4), 0);
            chk("async rst n1 valid_o", int'(vo1), 0);
            @(negedge clk);
            valid = 1'b0;
            rst_n = 1'b1;
            clr_models();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
